// File: rtl/mod_n_updown_counter_if.sv
// Control and status bundle for one modulo-N up/down counter stage.
// The master drives count commands; the slave (counter) returns count, carry and pulses.
interface mod_n_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-MODULUS up/down counter with enable, sync clear, parallel load and cascade carry.
// q/wrap/load_err update one edge after the command; tc is combinational. No backpressure.
module mod_n_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 7
) (
  input logic                   clk,
  input logic                   reset,
  mod_n_updown_counter_if.slave bus
);

  if ((WIDTH < 1) || (WIDTH > 16) || (MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_params
    $error("mod_n_updown_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic             at_top;
  logic             at_zero;
  logic             load_ok;

  assign at_top  = (q_q == TOP);
  assign at_zero = (q_q == '0);
  // Extra bit keeps the range check exact when MODULUS == 2**WIDTH.
  assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (bus.clear) begin
      q_d = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        q_d = bus.load_val;
      end else begin
        q_d    = TOP;
        lerr_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_top) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_d    = TOP;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = lerr_q;
  assign bus.tc       = bus.en & ~bus.clear & ~bus.load &
                        ((bus.up_dn & at_top) | (~bus.up_dn & at_zero));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter: expectations queued at drive time, checked after the edge.
module tb_mod_n_updown_counter;

  int n_chk  = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_n_updown_counter_if #(.WIDTH(3)) a_if ();
  mod_n_updown_counter_if #(.WIDTH(3)) e_if ();
  mod_n_updown_counter_if #(.WIDTH(4)) u_if ();
  mod_n_updown_counter_if #(.WIDTH(4)) t_if ();

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(7))  dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8))  dut_e (.clk(clk), .reset(reset), .bus(e_if.slave));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_u (.clk(clk), .reset(reset), .bus(u_if.slave));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_t (.clk(clk), .reset(reset), .bus(t_if.slave));

  assign t_if.en = u_if.tc;

  typedef struct {
    string tag;
    int    id;
    int    q;
    bit    wrap;
    bit    lerr;
  } exp_t;

  exp_t sb[$];
  int   mq[4];
  int   mods[4] = '{7, 8, 10, 10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_q(input int id);
    case (id)
      0:       return 32'(a_if.q);
      1:       return 32'(e_if.q);
      2:       return 32'(u_if.q);
      default: return 32'(t_if.q);
    endcase
  endfunction

  function automatic logic [31:0] get_wrap(input int id);
    case (id)
      0:       return 32'(a_if.wrap);
      1:       return 32'(e_if.wrap);
      2:       return 32'(u_if.wrap);
      default: return 32'(t_if.wrap);
    endcase
  endfunction

  function automatic logic [31:0] get_lerr(input int id);
    case (id)
      0:       return 32'(a_if.load_err);
      1:       return 32'(e_if.load_err);
      2:       return 32'(u_if.load_err);
      default: return 32'(t_if.load_err);
    endcase
  endfunction

  function automatic logic [31:0] get_tc(input int id);
    case (id)
      0:       return 32'(a_if.tc);
      1:       return 32'(e_if.tc);
      2:       return 32'(u_if.tc);
      default: return 32'(t_if.tc);
    endcase
  endfunction

  function automatic bit tc_model(input int m, input int q, input bit en, input bit up,
                                  input bit clr, input bit ld);
    return en && !clr && !ld && ((up && q == m - 1) || (!up && q == 0));
  endfunction

  function automatic void model(input int m, input int q, input bit en, input bit up,
                                input bit clr, input bit ld, input int lv,
                                output int nq, output bit nw, output bit nl);
    nq = q;
    nw = 1'b0;
    nl = 1'b0;
    if (clr) begin
      nq = 0;
    end else if (ld) begin
      if (lv < m) nq = lv;
      else begin
        nq = m - 1;
        nl = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (q == m - 1) begin nq = 0; nw = 1'b1; end
        else nq = q + 1;
      end else begin
        if (q == 0) begin nq = m - 1; nw = 1'b1; end
        else nq = q - 1;
      end
    end
  endfunction

  task automatic drive(input int id, input bit en, input bit up, input bit clr,
                       input bit ld, input int lv);
    if (id == 0) begin
      a_if.en = en; a_if.up_dn = up; a_if.clear = clr; a_if.load = ld; a_if.load_val = 3'(lv);
    end else begin
      e_if.en = en; e_if.up_dn = up; e_if.clear = clr; e_if.load = ld; e_if.load_val = 3'(lv);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "_q"},    get_q(e.id),    32'(e.q));
    check({e.tag, "_wrap"}, get_wrap(e.id), 32'(e.wrap));
    check({e.tag, "_lerr"}, get_lerr(e.id), 32'(e.lerr));
  endtask

  // One edge on a standalone instance (id 0 = mod 7, id 1 = mod 8).
  task automatic step(input int id, input string tag, input bit en, input bit up,
                      input bit clr, input bit ld, input int lv);
    exp_t e;
    int   nq;
    bit   nw, nl;
    @(negedge clk);
    drive(id, en, up, clr, ld, lv);
    #1;
    check({tag, "_tc"}, get_tc(id), 32'(tc_model(mods[id], mq[id], en, up, clr, ld)));
    model(mods[id], mq[id], en, up, clr, ld, lv, nq, nw, nl);
    e = '{tag, id, nq, nw, nl};
    sb.push_back(e);
    mq[id] = nq;
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic cascade_step(input int k);
    exp_t eu, et;
    int   nq;
    bit   nw, nl, ctc;
    string tag;
    tag = $sformatf("casc%0d", k);
    @(negedge clk);
    u_if.en = 1'b1;
    #1;
    ctc = tc_model(10, mq[2], 1'b1, 1'b1, 1'b0, 1'b0);
    check({tag, "_utc"}, get_tc(2), 32'(ctc));
    model(10, mq[2], 1'b1, 1'b1, 1'b0, 1'b0, 0, nq, nw, nl);
    eu = '{{tag, "_u"}, 2, nq, nw, nl};
    mq[2] = nq;
    model(10, mq[3], ctc, 1'b1, 1'b0, 1'b0, 0, nq, nw, nl);
    et = '{{tag, "_t"}, 3, nq, nw, nl};
    mq[3] = nq;
    sb.push_back(eu);
    sb.push_back(et);
    @(posedge clk);
    #1;
    pop_check();
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int up_tab[8];
    int dn_tab[8];
    up_tab = '{1, 2, 3, 4, 5, 6, 0, 1};
    dn_tab = '{6, 5, 4, 3, 2, 1, 0, 6};
    for (int i = 0; i < 4; i++) mq[i] = 0;

    reset = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    u_if.en = 1'b0; u_if.up_dn = 1'b1; u_if.clear = 1'b0; u_if.load = 1'b0; u_if.load_val = '0;
    t_if.up_dn = 1'b1; t_if.clear = 1'b0; t_if.load = 1'b0; t_if.load_val = '0;
    #2;
    check("rst_q",    get_q(0),    0);
    check("rst_wrap", get_wrap(0), 0);
    check("rst_lerr", get_lerr(0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(0, $sformatf("up%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 0);
      check($sformatf("up_tab%0d", i), get_q(0), 32'(up_tab[i]));
      check($sformatf("up_tabw%0d", i), get_wrap(0), 32'(up_tab[i] == 0));
    end

    step(0, "clr0", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, $sformatf("dn%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 0);
      check($sformatf("dn_tab%0d", i), get_q(0), 32'(dn_tab[i]));
      check($sformatf("dn_tabw%0d", i), get_wrap(0), 32'(dn_tab[i] == 6));
    end

    step(0, "ld3",      1'b0, 1'b1, 1'b0, 1'b1, 3);
    step(0, "ld5_en",   1'b1, 1'b0, 1'b0, 1'b1, 5);
    check("prio_ld5", get_q(0), 5);
    step(0, "clr_ld",   1'b1, 1'b1, 1'b1, 1'b1, 4);
    check("prio_clr", get_q(0), 0);
    step(0, "ld7",      1'b0, 1'b1, 1'b0, 1'b1, 7);
    check("ld7_sat",  get_q(0), 6);
    check("ld7_err",  get_lerr(0), 1);
    step(0, "hold",     1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("err_pulse", get_lerr(0), 0);
    step(0, "tc_up6",   1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(0, "dir_dn0",  1'b1, 1'b0, 1'b0, 1'b0, 0);

    step(0, "ld4", 1'b0, 1'b1, 1'b0, 1'b1, 4);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_q",    get_q(0),    0);
    check("midrst_wrap", get_wrap(0), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold%0d", i), get_q(0), 0);
    end
    mq[0] = 0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    reset = 1'b1;
    step(0, "post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 0);

    for (int k = 1; k <= 100; k++) begin
      cascade_step(k);
      if (k == 99) begin
        check("casc99_units", get_q(2), 9);
        check("casc99_tens",  get_q(3), 9);
      end
      if (k == 100) begin
        check("casc100_units", get_q(2), 0);
        check("casc100_tens",  get_q(3), 0);
        check("casc100_uwrap", get_wrap(2), 1);
        check("casc100_twrap", get_wrap(3), 1);
      end
    end
    @(negedge clk);
    u_if.en = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(1, $sformatf("m8up%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 0);
      if (i == 7) begin
        check("m8_wrap_q",   get_q(1),    0);
        check("m8_wrap_pls", get_wrap(1), 1);
      end
    end
    step(1, "m8_clr",  1'b1, 1'b1, 1'b1, 1'b0, 0);
    step(1, "m8_dn",   1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("m8_dn_q", get_q(1), 7);
    step(1, "m8_ld7",  1'b0, 1'b1, 1'b0, 1'b1, 7);
    check("m8_ld7_err", get_lerr(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
